fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the branch predictor's take/alt_address outputs.
- Owns the IF program counter and selects the next PC: reset vector, mispredict recovery, predicted-taken target, or PC+4.
- Keeps a small FIFO of in-flight predictions and checks each one against the ID-stage resolution.
- On a mispredict, flushes the FIFO, issues a one-cycle redirect to the correct PC, and counts the event.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 4, prediction FIFO entries (power of two).
PTR_W, 2, log2(DEPTH).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
STALL  input  1  pipeline stall; holds the PC and blocks push/pop.
Pred_Take  input  1  predictor requests taken redirect for current IF_PC.
Pred_Alt_Address  input  32  predicted target, valid when Pred_Take=1.
ID_Valid  input  1  an instruction occupies ID this cycle; pops one FIFO entry.
ID_Resolve  input  1  the ID instruction is a branch/jump (qualified by ID_Valid).
ID_Taken  input  1  actual branch outcome.
ID_Target  input  32  actual taken target.
IF_PC  output  32  current fetch PC (registered).
Redirect  output  1  one-cycle pulse; IF_PC is a recovery PC, so upstream squashes IF/ID.
Queue_Full  output  1  FIFO count == DEPTH.
Mispredict_Count  output  16  saturating mispredict counter.
Underflow  output  1  sticky; set when ID_Valid pops an empty FIFO.

Behaviour:
- Reset (RESET=1 at an edge, any cycle, including mid-recovery):
  - IF_PC=RESET_PC; FIFO pointers and count=0.
  - Redirect=0, Mispredict_Count=0, Underflow=0.
  - Reset overrides every other input.
- FIFO entry: {pc[31:0], take, target[31:0]}.
- Push: occurs when !STALL && !Queue_Full.
  - Stores {IF_PC, Pred_Take, Pred_Alt_Address}.
  - Full is evaluated before this cycle's pop. A full FIFO blocks the push even if a pop occurs the same cycle.
- Pop: occurs when !STALL && ID_Valid && count!=0. The head entry is compared combinationally that cycle.
- Mispredict detect (pop cycle only):
  - Case A: ID_Resolve=1 and head.take!=ID_Taken.
  - Case B: ID_Resolve=1, ID_Taken=1, head.take=1, head.target!=ID_Target.
  - Case C: ID_Resolve=0 and head.take=1 (taken predicted on a non-branch).
  - Correct PC: ID_Taken ? ID_Target : head.pc+4. Case C always uses head.pc+4.
  - All arithmetic is 32-bit, wrap-around modulo 2^32.
- Next-PC priority at each edge:
  1. RESET.
  2. Mispredict: IF_PC<=correct PC; FIFO cleared (count=0, rd=wr). Any same-cycle push is discarded.
  3. STALL or Queue_Full: hold IF_PC.
  4. Pred_Take: IF_PC<=Pred_Alt_Address.
  5. Otherwise IF_PC<=IF_PC+4.
- Redirect:
  - Registered; equals 1 in exactly the cycle after a detected mispredict, else 0.
  - Back-to-back detection is impossible, because the FIFO is empty after recovery.
- Mispredict_Count: increments by 1 per detected mispredict; saturates at 16'hFFFF.
- Underflow:
  - Set when !STALL && ID_Valid && count==0.
  - Cleared only by RESET.
  - No pop and no compare occur in that cycle.
- STALL=1: no push, no pop, no compare, no counter change. Redirect still deasserts after its single cycle.
- Simultaneous push and pop without mispredict: count unchanged; both pointers advance, wrapping modulo DEPTH.

Test Plan:
- Reset/sequential: RESET one cycle, RESET_PC=0x100, no predictions, no ID_Valid for 3 cycles -> IF_PC 0x100, 0x104, 0x108, 0x10C; Queue_Full=1 after 4 pushes; IF_PC holds at 0x110.
- Correct taken prediction: IF_PC=0x200 with Pred_Take=1, Pred_Alt_Address=0x400. Next cycle IF_PC=0x400. Pop with ID_Resolve=1, ID_Taken=1, ID_Target=0x400 -> Redirect stays 0, count unchanged.
- Direction mispredict: entry {0x200, take=0}; pop with ID_Resolve=1, ID_Taken=1, ID_Target=0x800 -> next cycle Redirect=1, IF_PC=0x800, FIFO empty, Mispredict_Count=1.
- Non-branch false taken: entry {0x300, take=1, 0x500}; pop with ID_Resolve=0 -> Redirect=1, IF_PC=0x304.
- Stall and wrap: cycle pushes/pops past DEPTH×3 with STALL asserted for 2 cycles mid-stream -> order is preserved, IF_PC held during stall, no count change; pop on empty sets Underflow=1 until RESET.
- Saturation: preload 65535 mispredicts (or force the counter), then one more -> Mispredict_Count stays 16'hFFFF. Assert RESET mid-redirect -> Redirect=0, IF_PC=RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Brief    : Owns the IF program counter. Follows predictor redirects, keeps
//            a FIFO of in-flight predictions, checks each against the ID-stage
//            resolution and recovers (flush + one-cycle Redirect) on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Pred_Take,
    input  logic [31:0] Pred_Alt_Address,
    input  logic        ID_Valid,
    input  logic        ID_Resolve,
    input  logic        ID_Taken,
    input  logic [31:0] ID_Target,
    output logic [31:0] IF_PC,
    output logic        Redirect,
    output logic        Queue_Full,
    output logic [15:0] Mispredict_Count,
    output logic        Underflow
);

    localparam logic [PTR_W:0] C_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [15:0]    C_CNT_MAX = 16'hFFFF;

    // Prediction FIFO storage, one entry per fetched PC
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic             r_fifo_take [DEPTH];
    logic [31:0]      r_fifo_tgt  [DEPTH];

    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_pc;
    logic             r_redirect;
    logic [15:0]      r_mispredict_count;
    logic             r_underflow;

    logic             w_full;
    logic             w_push;
    logic             w_push_eff;
    logic             w_pop;
    logic             w_underflow_evt;
    logic [31:0]      w_head_pc;
    logic             w_head_take;
    logic [31:0]      w_head_tgt;
    logic             w_mispredict;
    logic [31:0]      w_correct_pc;
    logic [31:0]      w_next_pc;

    assign w_head_pc   = r_fifo_pc[r_rd];
    assign w_head_take = r_fifo_take[r_rd];
    assign w_head_tgt  = r_fifo_tgt[r_rd];

    // Push/pop qualification, mispredict detection and next-PC selection.
    // Full is judged on the count before this cycle's pop, so a full FIFO
    // never accepts a push even when it is also being drained.
    always_comb begin
        w_full          = (r_count == C_DEPTH);
        w_push          = !STALL && !w_full;
        w_pop           = !STALL && ID_Valid && (r_count != '0);
        w_underflow_evt = !STALL && ID_Valid && (r_count == '0);

        w_mispredict = 1'b0;
        if (w_pop) begin
            if (ID_Resolve) begin
                w_mispredict = (w_head_take != ID_Taken) ||
                               (ID_Taken && w_head_take && (w_head_tgt != ID_Target));
            end else begin
                w_mispredict = w_head_take;
            end
        end

        // Non-branch (ID_Resolve=0) always recovers to the fall-through PC
        w_correct_pc = (ID_Resolve && ID_Taken) ? ID_Target : (w_head_pc + 32'd4);

        // A recovery flushes the queue, so this cycle's push must be dropped
        w_push_eff = w_push && !w_mispredict;

        if (w_mispredict) begin
            w_next_pc = w_correct_pc;
        end else if (STALL || w_full) begin
            w_next_pc = r_pc;
        end else if (Pred_Take) begin
            w_next_pc = Pred_Alt_Address;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    // FIFO data write; contents need no reset since count gates every read
    always_ff @(posedge CLK) begin
        if (w_push_eff) begin
            r_fifo_pc[r_wr]   <= r_pc;
            r_fifo_take[r_wr] <= Pred_Take;
            r_fifo_tgt[r_wr]  <= Pred_Alt_Address;
        end
    end

    // FIFO pointers and occupancy; a mispredict empties the queue in place
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (w_mispredict) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push_eff, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // PC register, redirect pulse, saturating mispredict counter, sticky underflow
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc               <= RESET_PC;
            r_redirect         <= 1'b0;
            r_mispredict_count <= '0;
            r_underflow        <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_redirect <= w_mispredict;
            if (w_mispredict && (r_mispredict_count != C_CNT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign IF_PC            = r_pc;
    assign Redirect         = r_redirect;
    assign Queue_Full       = (r_count == C_DEPTH);
    assign Mispredict_Count = r_mispredict_count;
    assign Underflow        = r_underflow;

endmodule
`default_nettype wire
